mesh_sort_ctrl: RTL and testbench

- Sequencer for the SQRT_N x SQRT_N sorting mesh of {addr,data} PEs.
- Runs one complete shearsort pass on a start pulse: load, alternating snake-row and column compare-exchange phases, final row phase, pipeline drain, then a done pulse.
- Sits beside the mesh and drives every PE's global control lines, so PEs hold no phase or step counters of their own.

---
 rtl/mesh_sort_ctrl.sv | 151 +++++++++++++++
 tb/tb_mesh_sort_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_sort_ctrl.sv
// mesh_sort_ctrl: sequencer for an SQRT_N x SQRT_N shearsort mesh.
// Drives the global PE control lines through one pass:
// load, alternating snake-row and column compare-exchange phases,
// final row phase, pipeline drain, then a done pulse.
// Optional feature macro: MESH_SORT_CTRL_STALL_EN adds a stall input.
// While stall is high in SORT or DRAIN, the controller holds its state and counters.
module mesh_sort_ctrl #(
  parameter int SQRT_N       = 8,
  parameter int LOG_SQRT_N   = 3,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
`ifdef MESH_SORT_CTRL_STALL_EN
  input  logic                  stall,
`endif
  output logic                  busy,
  output logic                  load_en,
  output logic                  ce_en,
  output logic                  ce_dim,
  output logic                  ce_parity,
  output logic                  snake_en,
  output logic [LOG_SQRT_N:0]   phase_idx,
  output logic [LOG_SQRT_N-1:0] step_idx,
  output logic                  done,
  output logic                  result_valid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SORT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Drain counter is at least one bit wide so DRAIN_CYCLES of 0 or 1 still elaborates.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [LOG_SQRT_N-1:0] LAST_STEP  = LOG_SQRT_N'(SQRT_N - 1);
  localparam logic [LOG_SQRT_N:0]   LAST_PHASE = (LOG_SQRT_N + 1)'(2 * LOG_SQRT_N);
  localparam logic [DW-1:0]         LAST_DRAIN = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;

  logic [2:0]              state_reg, state_next;
  logic [LOG_SQRT_N-1:0]   step_reg, step_next;
  logic [LOG_SQRT_N:0]     phase_reg, phase_next;
  logic [DW-1:0]           drain_reg, drain_next;
  logic                    rv_reg, rv_next;
  logic                    stall_w;

`ifdef MESH_SORT_CTRL_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Next-state and counter sequencing. Abort overrides everything, including start.
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    phase_next = phase_reg;
    drain_next = drain_reg;
    rv_next    = rv_reg;
    if (abort) begin
      state_next = S_IDLE;
      step_next  = '0;
      phase_next = '0;
      drain_next = '0;
      rv_next    = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_next = S_LOAD;
            rv_next    = 1'b0;
          end
        end
        S_LOAD: state_next = S_SORT;
        S_SORT: begin
          if (!stall_w) begin
            if (step_reg == LAST_STEP) begin
              step_next = '0;
              // The terminal phase is detected explicitly; the phase counter never wraps.
              if (phase_reg == LAST_PHASE) begin
                phase_next = '0;
                state_next = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
              end else begin
                phase_next = phase_reg + (LOG_SQRT_N + 1)'(1);
              end
            end else begin
              step_next = step_reg + LOG_SQRT_N'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!stall_w) begin
            if (drain_reg == LAST_DRAIN) begin
              drain_next = '0;
              state_next = S_DONE;
            end else begin
              drain_next = drain_reg + DW'(1);
            end
          end
        end
        S_DONE: state_next = S_IDLE;
        default: begin
          state_next = S_IDLE;
          step_next  = '0;
          phase_next = '0;
          drain_next = '0;
        end
      endcase
      // result_valid rises together with the done cycle.
      if (state_next == S_DONE && state_reg != S_DONE) begin
        rv_next = 1'b1;
      end
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      step_reg  <= '0;
      phase_reg <= '0;
      drain_reg <= '0;
      rv_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      phase_reg <= phase_next;
      drain_reg <= drain_next;
      rv_reg    <= rv_next;
    end
  end

  // Control lines decoded from state; step detail is zeroed whenever no step is active.
  always_comb begin
    busy         = (state_reg == S_LOAD) || (state_reg == S_SORT) || (state_reg == S_DRAIN);
    load_en      = (state_reg == S_LOAD);
    ce_en        = (state_reg == S_SORT) && !stall_w;
    ce_dim       = ce_en & phase_reg[0];
    snake_en     = ce_en & ~phase_reg[0];
    ce_parity    = ce_en & step_reg[0];
    phase_idx    = ce_en ? phase_reg : '0;
    step_idx     = ce_en ? step_reg : '0;
    done         = (state_reg == S_DONE);
    result_valid = rv_reg;
  end

endmodule

// File: tb/tb_mesh_sort_ctrl.sv
// tb_mesh_sort_ctrl: scoreboard bench for mesh_sort_ctrl with randomized start/abort traffic.
// Build with MESH_SORT_CTRL_STALL_EN defined to also exercise the stall input.
module tb_mesh_sort_ctrl;

  localparam int SQRT_N   = 8;
  localparam int LOG      = 3;
  localparam int DRAIN    = 2;
  localparam int NPH      = 2 * LOG + 1;
  localparam int SORT_CYC = NPH * SQRT_N;
  localparam int PASS_LEN = 1 + SORT_CYC + DRAIN;  // load cycle -> done cycle

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
`ifdef MESH_SORT_CTRL_STALL_EN
  logic stall = 1'b0;
`endif
  logic busy, load_en, ce_en, ce_dim, ce_parity, snake_en, done, result_valid;
  logic [LOG:0]   phase_idx;
  logic [LOG-1:0] step_idx;

  mesh_sort_ctrl #(.SQRT_N(SQRT_N), .LOG_SQRT_N(LOG), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef MESH_SORT_CTRL_STALL_EN
    .stall(stall),
`endif
    .busy(busy), .load_en(load_en), .ce_en(ce_en), .ce_dim(ce_dim),
    .ce_parity(ce_parity), .snake_en(snake_en), .phase_idx(phase_idx),
    .step_idx(step_idx), .done(done), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  typedef struct { int idx; int phase; int step; } ce_t;
  ce_t ce_q[$];
  int  load_q[$];
  int  done_q[$];

  // Reference model of the current pass
  bit pass_live = 0;
  int cur_load = 0;
  int cur_done_base = 0;
  int stall_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
  endtask

  function automatic int exp_done_c();
    return cur_done_base + stall_cnt;
  endfunction

  function automatic bit exp_busy(input int c);
    return pass_live && c >= cur_load && c < exp_done_c();
  endfunction

  function automatic bit model_idle(input int c);
    return !pass_live || c > exp_done_c();
  endfunction

  function automatic bit exp_rv(input int c);
    return pass_live && c >= exp_done_c();
  endfunction

  task automatic accept(input int l);
    ce_q.delete();
    pass_live = 1;
    cur_load = l;
    stall_cnt = 0;
    cur_done_base = l + PASS_LEN;
    load_q.push_back(l);
    done_q.push_back(cur_done_base);
    for (int p = 0; p < NPH; p++)
      for (int s = 0; s < SQRT_N; s++)
        ce_q.push_back('{idx: p * SQRT_N + s, phase: p, step: s});
  endtask

  task automatic apply_abort();
    pass_live = 0;
    ce_q.delete();
    load_q.delete();
    done_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit with_abort);
    int prev_c;
    prev_c = cyc;
    start = 1'b1;
    abort = with_abort;
    tick();
    if (with_abort) apply_abort();
    else if (model_idle(prev_c)) accept(cyc);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    apply_abort();
    abort = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pass_live && cyc <= exp_done_c() && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("done_timeout", n, 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {busy, load_en, ce_en, ce_dim, ce_parity, snake_en, phase_idx, step_idx,
               done, result_valid}, 0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, exp_busy(cyc));
      chk("result_valid", result_valid, exp_rv(cyc));
      if (load_en) begin
        if (load_q.size() == 0) chk("load_en_unexpected", load_en, 0);
        else chk("load_cycle", cyc, load_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", done, 0);
        else chk("done_cycle", cyc, done_q.pop_front() + stall_cnt);
      end
      if (ce_en) begin
        if (ce_q.size() == 0) chk("ce_en_unexpected", ce_en, 0);
        else begin
          ce_t e;
          e = ce_q.pop_front();
          chk("ce_cycle", cyc, cur_load + 1 + e.idx + stall_cnt);
          chk("phase_idx", phase_idx, e.phase);
          chk("step_idx", step_idx, e.step);
          chk("ce_dim", ce_dim, e.phase % 2);
          chk("ce_parity", ce_parity, e.step % 2);
          chk("snake_en", snake_en, (e.phase % 2 == 0) ? 1 : 0);
        end
      end else begin
        chk("idle_ctrl_zero", {ce_dim, ce_parity, snake_en, phase_idx, step_idx}, 0);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int l;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    rst = 1'b0;
    tick();

    // Single pass with ignored extra starts while busy and in DONE
    do_start(0);
    l = cur_load;
    while (cyc < l + 9) tick();
    do_start(0);
    while (cyc < l + PASS_LEN) tick();
    do_start(0);
    wait_idle();
    tick();
    chk("rv_after_pass", result_valid, 1);

    // Abort at SORT step 20, then a fresh complete pass
    do_start(0);
    l = cur_load;
    while (cyc < l + 21) tick();
    do_abort();
    chk_all_zero("after_abort");
    tick();
    do_start(0);
    wait_idle();
    tick();
    chk("rv_after_restart", result_valid, 1);

    // Asynchronous reset in the middle of DRAIN
    do_start(0);
    l = cur_load;
    while (cyc < l + SORT_CYC + 1) tick();
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst_drain");
    apply_abort();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Start and abort together in IDLE after a completed pass
    do_start(0);
    wait_idle();
    tick();
    do_start(1);
    tick();
    tick();
    chk("rv_start_abort", result_valid, 0);

`ifdef MESH_SORT_CTRL_STALL_EN
    // Stall for five cycles during phase 3
    do_start(0);
    l = cur_load;
    while (cyc < l + 1 + 3 * SQRT_N + 2) tick();
    for (int i = 0; i < 5; i++) begin
      stall = 1'b1;
      stall_cnt++;
      tick();
    end
    stall = 1'b0;
    wait_idle();
    chk("stall_done_offset", exp_done_c() - l, PASS_LEN + 5);
    tick();
`endif

    // Randomized traffic: gaps, spurious starts, random aborts
    for (int it = 0; it < 25; it++) begin
      int gap, abort_at;
      gap = $urandom_range(0, 4);
      repeat (gap) tick();
      do_start(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, PASS_LEN + 3) : -1;
      for (int k = 0; k < PASS_LEN + 6; k++) begin
        if (k == abort_at) do_abort();
        else if ($urandom_range(0, 9) == 0) do_start(1'b0);
        else tick();
      end
      wait_idle();
      tick();
    end

    chk("ce_q_empty", ce_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("load_q_empty", load_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
